// File: rtl/rf_writeback.sv
// Write-back stage: merges ALU and load results onto the single RF write port,
// buffers one load while the ALU owns the port, and tracks outstanding loads.
module rf_writeback #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_issue,
  input  logic [AW-1:0]   ld_issue_rd,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [AW-1:0]   ld_rd,
  input  logic [XLEN-1:0] ld_data,
  input  logic [AW-1:0]   chk_rs1,
  input  logic [AW-1:0]   chk_rs2,
  input  logic [AW-1:0]   chk_rd,
  output logic            stall,
  output logic [NREG-1:0] busy_mask,
  output logic            rf_write_e,
  output logic [AW-1:0]   rf_rd,
  output logic [XLEN-1:0] rf_write_d
);

  logic            buf_valid_q, buf_valid_d;
  logic [AW-1:0]   buf_rd_q, buf_rd_d;
  logic [XLEN-1:0] buf_data_q, buf_data_d;

  logic [NREG-1:0] busy_q, busy_d;

  logic            we_q, we_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [XLEN-1:0] wd_q, wd_d;

  logic alu_eff;
  logic drain;
  logic ld_acc;

  assign alu_eff  = alu_valid && (alu_rd != '0);
  assign drain    = buf_valid_q && !alu_eff;
  assign ld_ready = !buf_valid_q || drain;
  assign ld_acc   = ld_valid && ld_ready;

  // Port mux: ALU first, then the buffered load.
  always_comb begin
    we_d = 1'b0;
    rd_d = rd_q;
    wd_d = wd_q;
    if (alu_eff) begin
      we_d = 1'b1;
      rd_d = alu_rd;
      wd_d = alu_data;
    end else if (drain) begin
      we_d = 1'b1;
      rd_d = buf_rd_q;
      wd_d = buf_data_q;
    end
  end

  // Loads to x0 complete the handshake but never occupy the buffer.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_rd_d    = buf_rd_q;
    buf_data_d  = buf_data_q;
    if (drain) begin
      buf_valid_d = 1'b0;
    end
    if (ld_acc && (ld_rd != '0)) begin
      buf_valid_d = 1'b1;
      buf_rd_d    = ld_rd;
      buf_data_d  = ld_data;
    end
  end

  // Set is applied after clear so a same-cycle issue wins.
  always_comb begin
    busy_d = busy_q;
    if (drain) begin
      busy_d[buf_rd_q] = 1'b0;
    end
    if (ld_issue && (ld_issue_rd != '0)) begin
      busy_d[ld_issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_q <= 1'b0;
      buf_rd_q    <= '0;
      buf_data_q  <= '0;
      busy_q      <= '0;
      we_q        <= 1'b0;
      rd_q        <= '0;
      wd_q        <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_rd_q    <= buf_rd_d;
      buf_data_q  <= buf_data_d;
      busy_q      <= busy_d;
      we_q        <= we_d;
      rd_q        <= rd_d;
      wd_q        <= wd_d;
    end
  end

  assign stall = busy_q[chk_rs1] | busy_q[chk_rs2] | busy_q[chk_rd];

  assign busy_mask  = busy_q;
  assign rf_write_e = we_q;
  assign rf_rd      = rd_q;
  assign rf_write_d = wd_q;

endmodule
